mac16_dot_sequencer: RTL and testbench

Controller that drives one SB_MAC16 tile configured as a registered 16x16 signed multiply-accumulator. It accepts a vector length and a stream of operand pairs, clears and flushes the MAC, feeds the operands, waits out the MAC pipeline, then returns the 32-bit accumulated dot product on a valid/ready result port. It sits between a data source and the MAC's A/B/O/ORST pins as the driving end of the MAC interface.

---
 rtl/mac16_dot_sequencer.sv | 142 ++++++++++++++
 tb/tb_mac16_dot_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac16_dot_sequencer.sv
// Sequencer that drives one SB_MAC16 as a registered 16x16 signed multiply-accumulator:
// clear/flush, stream operand pairs, drain the MAC pipeline and return the dot product.
module mac16_dot_sequencer #(
    parameter int VEC_LEN_W   = 8,
    parameter int MAC_LATENCY = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [VEC_LEN_W-1:0] cfg_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_a,
    input  logic [15:0]          in_b,
    output logic [15:0]          mac_a,
    output logic [15:0]          mac_b,
    output logic                 mac_orst,
    input  logic [31:0]          mac_o,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [31:0]          res_data,
    output logic                 busy
);

    localparam int CNT_W = $clog2(MAC_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_STREAM,
        S_DRAIN,
        S_RESULT
    } state_e;

    state_e               state_q, state_d;
    logic [VEC_LEN_W-1:0] len_q, len_d;
    logic [VEC_LEN_W-1:0] elem_cnt_q, elem_cnt_d;
    logic [CNT_W-1:0]     wait_cnt_q, wait_cnt_d;
    logic [15:0]          mac_a_q, mac_a_d;
    logic [15:0]          mac_b_q, mac_b_d;
    logic                 res_valid_q, res_valid_d;
    logic [31:0]          res_data_q, res_data_d;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves one unassigned (no latches).
        state_d     = state_q;
        len_d       = len_q;
        elem_cnt_d  = elem_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        mac_a_d     = '0;
        mac_b_d     = '0;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        in_ready    = 1'b0;
        mac_orst    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = cfg_len;
                    elem_cnt_d = '0;
                    wait_cnt_d = CNT_W'(MAC_LATENCY);
                    state_d    = S_CLEAR;
                end
            end
            S_CLEAR: begin
                // Zero operands while the accumulator is held in reset flushes stale products.
                mac_orst   = 1'b1;
                wait_cnt_d = wait_cnt_q - CNT_W'(1);
                if (wait_cnt_q == CNT_W'(1)) begin
                    if (len_q == '0) begin
                        wait_cnt_d = CNT_W'(MAC_LATENCY);
                        state_d    = S_DRAIN;
                    end else begin
                        state_d = S_STREAM;
                    end
                end
            end
            S_STREAM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mac_a_d    = in_a;
                    mac_b_d    = in_b;
                    elem_cnt_d = elem_cnt_q + VEC_LEN_W'(1);
                    if (elem_cnt_d == len_q) begin
                        wait_cnt_d = CNT_W'(MAC_LATENCY);
                        state_d    = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                // Counts MAC_LATENCY down to 0, giving MAC_LATENCY+1 drain cycles.
                wait_cnt_d = wait_cnt_q - CNT_W'(1);
                if (wait_cnt_q == '0) begin
                    wait_cnt_d  = '0;
                    res_data_d  = mac_o;
                    res_valid_d = 1'b1;
                    state_d     = S_RESULT;
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state flops use non-blocking assignments and reset asynchronously on rst_n low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            elem_cnt_q  <= '0;
            wait_cnt_q  <= '0;
            mac_a_q     <= '0;
            mac_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            elem_cnt_q  <= elem_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            mac_a_q     <= mac_a_d;
            mac_b_q     <= mac_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

    assign mac_a     = mac_a_q;
    assign mac_b     = mac_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac16_dot_sequencer.sv
// Bench for mac16_dot_sequencer: behavioural MAC tile, table vectors, corner sequences
// and randomized dot products checked against a plain-arithmetic reference.
module tb_mac16_dot_sequencer;

    localparam int VEC_LEN_W   = 8;
    localparam int MAC_LATENCY = 3;

    logic                 clk;
    logic                 rst_n;
    logic                 start;
    logic [VEC_LEN_W-1:0] cfg_len;
    logic                 in_valid;
    logic                 in_ready;
    logic [15:0]          in_a;
    logic [15:0]          in_b;
    logic [15:0]          mac_a;
    logic [15:0]          mac_b;
    logic                 mac_orst;
    logic [31:0]          mac_o;
    logic                 res_valid;
    logic                 res_ready;
    logic [31:0]          res_data;
    logic                 busy;

    mac16_dot_sequencer #(
        .VEC_LEN_W  (VEC_LEN_W),
        .MAC_LATENCY(MAC_LATENCY)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .cfg_len  (cfg_len),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .mac_a    (mac_a),
        .mac_b    (mac_b),
        .mac_orst (mac_orst),
        .mac_o    (mac_o),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // SB_MAC16 tile: input regs, product reg, accumulator reg; not reset by rst_n, starts with junk.
    logic [15:0]        a_r = 16'h1234;
    logic [15:0]        b_r = 16'h5678;
    logic signed [31:0] p_r = 32'sh0BAD_F00D;
    logic [31:0]        acc = 32'hDEAD_BEEF;
    always @(posedge clk) begin
        a_r <= mac_a;
        b_r <= mac_b;
        p_r <= $signed(a_r) * $signed(b_r);
        acc <= mac_orst ? 32'd0 : acc + p_r;
    end
    assign mac_o = acc;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    logic [15:0] op_a[256];
    logic [15:0] op_b[256];
    int          op_gap[256];

    function automatic logic [31:0] ref_dot(input int len);
        int sum = 0;
        for (int i = 0; i < len; i++)
            sum += int'($signed(op_a[i])) * int'($signed(op_b[i]));
        return sum;
    endfunction

    // Runs one operation from IDLE; entered and left at 1 time unit after a rising edge.
    task automatic do_op(input int len, input int rstall, input bit poke, input logic [31:0] exp_data,
                         input int exp_lat, input int exp_rdy, input string name);
        int  s_edge, idx, gap_left, rdy_cycles, orst_cycles;
        bit  done;
        start   = 1'b1;
        cfg_len = VEC_LEN_W'(len);
        @(posedge clk); #1;
        start       = 1'b0;
        s_edge      = edge_cnt;
        idx         = 0;
        gap_left    = (len > 0) ? op_gap[0] : 0;
        rdy_cycles  = 0;
        orst_cycles = 0;
        done        = 1'b0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            if (res_valid) begin
                done = 1'b1;
            end else begin
                if (mac_orst) orst_cycles++;
                in_valid = 1'b0;
                if (in_ready) begin
                    rdy_cycles++;
                    if (idx < len) begin
                        if (gap_left > 0) begin
                            gap_left--;
                        end else begin
                            in_valid = 1'b1;
                            in_a     = op_a[idx];
                            in_b     = op_b[idx];
                            idx++;
                            gap_left = (idx < len) ? op_gap[idx] : 0;
                        end
                    end
                end
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            check({name, " timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, " latency"}, edge_cnt - s_edge, exp_lat);
            check({name, " data"}, res_data, exp_data);
        end
        check({name, " ready_cycles"}, rdy_cycles, exp_rdy);
        check({name, " orst_cycles"}, orst_cycles, MAC_LATENCY);
        for (int k = 0; k < rstall; k++) begin
            res_ready = 1'b0;
            if (poke && k == 1) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            check({name, " held_valid"}, res_valid, 1'b1);
            check({name, " held_data"}, res_data, exp_data);
            if (poke) check({name, " busy_in_result"}, busy, 1'b1);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({name, " busy_after"}, busy, 1'b0);
        check({name, " valid_after"}, res_valid, 1'b0);
    endtask

    typedef struct {
        int               len;
        logic [3:0][15:0] a;
        logic [3:0][15:0] b;
        int               gap;
        int               rstall;
        bit               poke;
        logic [31:0]      exp_data;
        int               exp_lat;
        int               exp_rdy;
    } vec_t;

    vec_t tbl[6];

    task automatic check_reset_outputs(input string name);
        check({name, " in_ready"}, in_ready, 1'b0);
        check({name, " res_valid"}, res_valid, 1'b0);
        check({name, " res_data"}, res_data, 32'd0);
        check({name, " mac_a"}, mac_a, 16'd0);
        check({name, " mac_b"}, mac_b, 16'd0);
        check({name, " mac_orst"}, mac_orst, 1'b0);
        check({name, " busy"}, busy, 1'b0);
    endtask

    initial begin
        int gsum, len, waited;
        rst_n     = 1'b0;
        start     = 1'b0;
        cfg_len   = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
        #2;
        check_reset_outputs("reset");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Packed arrays: element 0 is the rightmost field.
        tbl[0] = '{4, {16'd4, 16'd3, 16'd2, 16'd1}, {16'd8, 16'd7, 16'd6, 16'd5}, 0, 0, 1'b0, 32'd70, 11, 4};
        tbl[1] = '{1, {48'd0, 16'hFFFD}, {48'd0, 16'd7}, 0, 0, 1'b0, 32'hFFFF_FFEB, 8, 1};
        tbl[2] = '{2, {32'd0, 16'h8000, 16'h8000}, {32'd0, 16'h8000, 16'h8000}, 0, 0, 1'b0, 32'h8000_0000, 9, 2};
        tbl[3] = '{3, {16'd0, 16'd2, 16'hFFFF, 16'd10}, {16'd0, 16'd3, 16'd4, 16'd10}, 2, 0, 1'b0, 32'd102, 14, 7};
        tbl[4] = '{0, 64'd0, 64'd0, 0, 0, 1'b0, 32'd0, 7, 0};
        tbl[5] = '{2, {32'd0, 16'd3, 16'd2}, {32'd0, 16'd5, 16'd4}, 0, 5, 1'b1, 32'd23, 9, 2};

        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 4; j++) begin
                op_a[j]   = tbl[i].a[j];
                op_b[j]   = tbl[i].b[j];
                op_gap[j] = (j == 0) ? 0 : tbl[i].gap;
            end
            do_op(tbl[i].len, tbl[i].rstall, tbl[i].poke, tbl[i].exp_data,
                  tbl[i].exp_lat, tbl[i].exp_rdy, $sformatf("vec%0d", i));
        end

        // Reset mid-stream after two accepted pairs; MAC keeps the junk products.
        start   = 1'b1;
        cfg_len = VEC_LEN_W'(4);
        @(posedge clk); #1;
        start  = 1'b0;
        waited = 0;
        while (!in_ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        check("abort ready_seen", in_ready, 1'b1);
        in_valid = 1'b1;
        in_a     = 16'd100;
        in_b     = 16'd100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op_a[0] = 16'd3; op_b[0] = 16'd5; op_gap[0] = 0;
        op_a[1] = 16'd4; op_b[1] = 16'd6; op_gap[1] = 0;
        do_op(2, 0, 1'b0, 32'd39, 2 * MAC_LATENCY + 2 + 1, 2, "after_abort");

        // Maximum length.
        for (int j = 0; j < 255; j++) begin
            op_a[j]   = 16'h7FFF;
            op_b[j]   = 16'h8001;
            op_gap[j] = 0;
        end
        do_op(255, 0, 1'b0, ref_dot(255), 2 * MAC_LATENCY + 255 + 1, 255, "max_len");

        // Random vectors, bubbles and result backpressure.
        for (int r = 0; r < 25; r++) begin
            len  = $urandom_range(0, 10);
            gsum = 0;
            for (int j = 0; j < len; j++) begin
                op_a[j]   = 16'($urandom);
                op_b[j]   = 16'($urandom);
                op_gap[j] = $urandom_range(0, 2);
                gsum += op_gap[j];
            end
            do_op(len, $urandom_range(0, 3), 1'b0, ref_dot(len),
                  2 * MAC_LATENCY + len + 1 + gsum, len + gsum, $sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
